generic1_sched: RTL and testbench

//  Two-requester scheduler for the generic1 code/pack datapath.
//  - Arbitrates round-robin between two operand sources and captures one a/b/mode job.
//  - Computes the 8-bit code word with the generic1 mode table.
//  - Packs the result into a 32-bit status word and holds it until downstream accepts.
//  - Sits between the operand producers and the result consumer; one job in flight.

---
 rtl/generic1_sched.sv | 98 +++++++++
 tb/tb_generic1_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic1_sched.sv
// Two-source round-robin scheduler: captures one a/b/mode job, computes the generic1 code, packs a 32-bit status word.
// Latency: accept in cycle N -> out_valid in cycle N+2; one job in flight, accepts spaced >= 3 cycles.
// Backpressure: result held in HOLD until out_ready; req_ready is low outside IDLE, so producers stall.
module generic1_sched #(
    parameter int DW    = 8,
    parameter int SEQ_W = 8
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    input  logic [5:0]      req_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_word,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    typedef struct packed {
        logic       src;
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
    } job_t;

    state_t           state;
    job_t             job;
    job_t             nxt_job;
    logic             rr_last;
    logic             gnt;
    logic [7:0]       code;
    logic [SEQ_W-1:0] seq;

    // With both sources valid, the one not granted last wins; otherwise the lone requester.
    always_comb begin
        gnt          = (&req_valid) ? ~rr_last : req_valid[1];
        req_ready    = 2'b00;
        if (reset && state == IDLE && |req_valid) begin
            req_ready[gnt] = 1'b1;
        end
        nxt_job.src  = gnt;
        nxt_job.mode = gnt ? req_mode[5:3]    : req_mode[2:0];
        nxt_job.a    = gnt ? req_a[DW +: 8]   : req_a[0 +: 8];
        nxt_job.b    = gnt ? req_b[DW +: 8]   : req_b[0 +: 8];
    end

    always_comb begin
        code = 8'h00;
        case (job.mode)
            3'b000, 3'b110: code = {3'b110, job.a[4:0]};
            3'b101:         code = 8'hE2;
            3'b010:         code = 8'hFF;
            3'b011:         code = 8'h00;
            default:        code = job.a + job.b;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            job       <= '0;
            rr_last   <= 1'b1;
            seq       <= '0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        job     <= nxt_job;
                        rr_last <= gnt;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    out_word  <= {job.src, job.mode, code, seq[7:0], job.a[6:0], 5'b11001};
                    out_valid <= 1'b1;
                    seq       <= seq + 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generic1_sched.sv
// Randomized + directed bench for generic1_sched against a cycle-count reference model.
module tb_generic1_sched;
    localparam int DW = 8;

    logic            sysclk = 1'b0;
    logic            reset  = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [5:0]      req_mode = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_word;
    logic            busy;

    int tests = 0;
    int fails = 0;

    always #5 sysclk = ~sysclk;

    generic1_sched #(.DW(DW), .SEQ_W(8)) dut (
        .sysclk(sysclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit f_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    function automatic logic [7:0] f_code(input logic [2:0] md, input logic [7:0] a, input logic [7:0] b);
        if (md == 3'd0 || md == 3'd6) return {3'b110, a[4:0]};
        if (md == 3'd5) return 8'hE2;
        if (md == 3'd2) return 8'hFF;
        if (md == 3'd3) return 8'h00;
        return a + b;
    endfunction

    function automatic logic [31:0] f_word(input logic [1:0] v, input bit last, input logic [15:0] a,
                                           input logic [15:0] b, input logic [5:0] md, input int sq);
        bit         g;
        logic [7:0] aa, bb;
        logic [2:0] mm;
        g  = f_grant(v, last);
        aa = g ? a[15:8] : a[7:0];
        bb = g ? b[15:8] : b[7:0];
        mm = g ? md[5:3] : md[2:0];
        return {g, mm, f_code(mm, aa, bb), 8'(sq), aa[6:0], 5'b11001};
    endfunction

    // Model: a job accepted in cycle c shows its result from cycle c+2; the block is free
    // again the cycle after the result is taken.
    bit          m_pend   = 1'b0;
    int          m_out_at = 0;
    int          cyc      = 0;
    logic [31:0] m_word   = 32'h0;
    logic [31:0] m_pword  = 32'h0;
    bit          m_last   = 1'b1;
    int          m_seq    = 0;

    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            m_pend <= 1'b0; m_out_at <= 0; cyc <= 0; m_word <= 32'h0;
            m_pword <= 32'h0; m_last <= 1'b1; m_seq <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_pend) begin
                if (cyc + 1 == m_out_at) m_word <= m_pword;
                if (cyc >= m_out_at && out_ready) m_pend <= 1'b0;
            end else if (req_valid != 2'b00) begin
                m_pword  <= f_word(req_valid, m_last, req_a, req_b, req_mode, m_seq);
                m_last   <= f_grant(req_valid, m_last);
                m_seq    <= (m_seq + 1) % 256;
                m_pend   <= 1'b1;
                m_out_at <= cyc + 2;
            end
        end
    end

    always @(negedge sysclk) begin
        logic [1:0] exp_rdy;
        exp_rdy = 2'b00;
        if (reset && !m_pend && req_valid != 2'b00)
            exp_rdy = f_grant(req_valid, m_last) ? 2'b10 : 2'b01;
        chk("cmp_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("cmp_out_valid", 32'(out_valid), 32'(m_pend && cyc >= m_out_at));
        chk("cmp_busy",      32'(busy),      32'(m_pend));
        chk("cmp_out_word",  out_word,       m_word);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_out(output int k, output bit ok);
        ok = 1'b0; k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sysclk);
            if (out_valid) begin k = i; ok = 1'b1; break; end
        end
    endtask

    task automatic do_job(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [2:0] md,
                          input bit ordy, output logic [31:0] w, output int lat);
        bit ok;
        int k;
        @(posedge sysclk); #2;
        out_ready = ordy;
        req_valid = s ? 2'b10 : 2'b01;
        req_a     = s ? {a, 8'($urandom)} : {8'($urandom), a};
        req_b     = s ? {b, 8'($urandom)} : {8'($urandom), b};
        req_mode  = s ? {md, 3'($urandom)} : {3'($urandom), md};
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (req_ready[s]) begin ok = 1'b1; break; end
        end
        chk("grant_wait", 32'(ok), 32'd1);
        @(posedge sysclk); #2;
        req_valid = 2'b00;
        wait_out(k, ok);
        chk("out_wait", 32'(ok), 32'd1);
        w   = out_word;
        lat = k;
    endtask

    task automatic pulse_reset();
        @(posedge sysclk); #2;
        reset = 1'b0;
        @(posedge sysclk); #2;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, w0, exp_w;
        logic [7:0]  codes [5];
        logic [2:0]  modes [5];
        int          lat, k;
        bit          ok;

        // Reset state with both sources requesting.
        #1 reset = 1'b0;
        req_valid = 2'b11;
        out_ready = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word",  out_word,       32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge sysclk); #2;
        reset = 1'b1;

        // 1: persistent requesters alternate, src0 first.
        for (int j = 0; j < 6; j++) begin
            wait_out(k, ok);
            chk("alt_wait", 32'(ok), 32'd1);
            chk("alt_src", 32'(out_word[31]), 32'(j % 2));
        end
        @(posedge sysclk); #2;
        req_valid = 2'b00;

        // 2: single job, latency and full word.
        pulse_reset();
        do_job(1'b0, 8'h13, 8'h22, 3'b001, 1'b1, w, lat);
        exp_w = {1'b0, 3'b001, 8'h35, 8'h00, 7'h13, 5'b11001};
        chk("t2_latency", 32'(lat), 32'd2);
        chk("t2_word", w, exp_w);

        // 3: constant modes and carry drop.
        modes[0] = 3'b101; codes[0] = 8'hE2;
        modes[1] = 3'b010; codes[1] = 8'hFF;
        modes[2] = 3'b011; codes[2] = 8'h00;
        modes[3] = 3'b110; codes[3] = 8'hDF;
        modes[4] = 3'b111; codes[4] = 8'h00;
        for (int j = 0; j < 5; j++) begin
            do_job(j[0], 8'hFF, 8'h01, modes[j], 1'b1, w, lat);
            chk("t3_code", 32'(w[27:20]), 32'(codes[j]));
        end

        // 4: stall in HOLD for 10 cycles.
        do_job(1'b1, 8'h5A, 8'h11, 3'b100, 1'b0, w0, lat);
        for (int j = 0; j < 10; j++) begin
            @(posedge sysclk); #2;
            req_valid = 2'($urandom_range(1, 3));
            @(negedge sysclk);
            chk("t4_word_stable", out_word, w0);
            chk("t4_req_ready",   32'(req_ready), 32'd0);
            chk("t4_valid_held",  32'(out_valid), 32'd1);
        end
        @(posedge sysclk); #2;
        out_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge sysclk);
        chk("t4_xfer_valid", 32'(out_valid), 32'd1);
        @(negedge sysclk);
        chk("t4_after_valid", 32'(out_valid), 32'd0);
        chk("t4_after_busy",  32'(busy),      32'd0);
        chk("t4_word_kept",   out_word,       w0);

        // 5: sequence counter wraps after 256 jobs.
        pulse_reset();
        for (int j = 0; j < 257; j++) begin
            do_job(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, w, lat);
            chk("t5_seq", 32'(w[19:12]), 32'(j % 256));
        end

        // Random traffic checked by the model each cycle.
        for (int j = 0; j < 3000; j++) begin
            @(posedge sysclk); #2;
            req_valid = 2'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_mode  = 6'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge sysclk); #2;
        req_valid = 2'b00;
        out_ready = 1'b1;
        repeat (5) @(posedge sysclk);

        // 6a: reset in HOLD.
        do_job(1'b1, 8'h77, 8'h01, 3'b001, 1'b0, w, lat);
        #1 reset = 1'b0;
        #1;
        chk("t6h_valid", 32'(out_valid), 32'd0);
        chk("t6h_word",  out_word,       32'd0);
        chk("t6h_busy",  32'(busy),      32'd0);
        @(posedge sysclk); #2;
        reset = 1'b1;
        out_ready = 1'b1;

        // 6b: reset mid-EXEC.
        do_job(1'b1, 8'h42, 8'h03, 3'b001, 1'b1, w, lat);
        @(posedge sysclk); #2;
        req_valid = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (req_ready[0]) begin ok = 1'b1; break; end
        end
        chk("t6e_grant", 32'(ok), 32'd1);
        @(posedge sysclk); #2;
        reset = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("t6e_valid", 32'(out_valid), 32'd0);
        chk("t6e_word",  out_word,       32'd0);
        chk("t6e_busy",  32'(busy),      32'd0);
        @(posedge sysclk); #2;
        reset = 1'b1;

        // 6c: reset during an IDLE grant; src1 would have won, src0 wins after reset.
        do_job(1'b0, 8'h01, 8'h02, 3'b001, 1'b1, w, lat);
        @(posedge sysclk); #2;
        req_valid = 2'b11;
        @(negedge sysclk);
        chk("t6i_pre_ready", 32'(req_ready), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("t6i_ready", 32'(req_ready), 32'd0);
        chk("t6i_busy",  32'(busy),      32'd0);
        @(posedge sysclk); #2;
        reset = 1'b1;
        @(negedge sysclk);
        chk("t6i_post_ready", 32'(req_ready), 32'd1);
        @(posedge sysclk); #2;
        req_valid = 2'b00;
        repeat (5) @(posedge sysclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
